// File: rtl/alu32_pkg.sv
// Shared definitions for the alu32 block: datapath width default, opcode
// encodings and the shifter mode type used between the top and the shifter.
package alu_pkg;

    // Default operand/result width of the datapath.
    localparam int ALU_WIDTH = 32;

    // Opcode encodings presented on ALUOp.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b100;
    localparam logic [2:0] ALU_SRA = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    // Direction / fill selection for the barrel shifter.
    typedef enum logic [1:0] {
        SHIFT_SRL = 2'd0,   // right, zero fill
        SHIFT_SRA = 2'd1,   // right, sign fill
        SHIFT_SLL = 2'd2    // left, zero fill
    } shift_mode_e;

    // Map an opcode onto the shifter mode; non-shift opcodes default to srl,
    // whose output is simply not selected by the result mux.
    function automatic shift_mode_e shift_mode_of(input logic [2:0] op);
        shift_mode_e mode;
        mode = SHIFT_SRL;
        if (op == ALU_SRA) begin
            mode = SHIFT_SRA;
        end else if (op == ALU_SLL) begin
            mode = SHIFT_SLL;
        end
        return mode;
    endfunction

endpackage : alu_pkg

// File: rtl/alu32_if.sv
// Operand/opcode/result bundle for alu32. The master drives operands and
// opcode and receives the registered result; the ALU is the slave.
interface alu32_if #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
);
    logic [WIDTH-1:0] A;       // first operand, also the shift source
    logic [WIDTH-1:0] B;       // second operand, low bits give shift amount
    logic [2:0]       ALUOp;   // operation select
    logic [WIDTH-1:0] C;       // registered result

    modport master (
        output A,
        output B,
        output ALUOp,
        input  C
    );

    modport slave (
        input  A,
        input  B,
        input  ALUOp,
        output C
    );
endinterface : alu32_if

// File: rtl/alu32_shifter.sv
// alu_shifter: combinational log2(WIDTH)-stage barrel shifter serving srl,
// sra and sll. Left shifts reuse the right-shift network by reversing the
// bit order on the way in and on the way out, so only one ladder is built.
module alu_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amount,
    input  shift_mode_e      mode,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] data_rev;
    logic [WIDTH-1:0] ladder_in;
    logic [WIDTH-1:0] ladder_out;
    logic [WIDTH-1:0] ladder_rev;
    logic             fill_bit;
    logic             is_left;
    logic [WIDTH-1:0] stage [0:SHW];

    genvar gi;

    // Bit-reversed copies of the input and of the ladder output.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign data_rev[gi]   = data[WIDTH-1-gi];
            assign ladder_rev[gi] = ladder_out[WIDTH-1-gi];
        end
    endgenerate

    assign is_left   = (mode == SHIFT_SLL);
    assign fill_bit  = (mode == SHIFT_SRA) ? data[WIDTH-1] : 1'b0;
    assign ladder_in = is_left ? data_rev : data;
    assign stage[0]  = ladder_in;

    // Stage gi shifts right by 2**gi when amount bit gi is set.
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int STEP = 1 << gi;
            assign stage[gi+1] = amount[gi]
                ? {{STEP{fill_bit}}, stage[gi][WIDTH-1:STEP]}
                : stage[gi];
        end
    endgenerate

    assign ladder_out = stage[SHW];

    // Undo the input reversal for left shifts.
    always_comb begin
        result = ladder_out;
        if (is_left) begin
            result = ladder_rev;
        end
    end

endmodule : alu_shifter

// File: rtl/alu32.sv
// alu32: 32-bit ALU with a registered result (one-cycle latency, a new
// operation every cycle). Opcodes 110 (slt) and 111 (sll) are implemented
// only when the macro ALU_EXT_OPS_EN is defined; otherwise they yield zero.
// Reset is asynchronous and active-low and clears the result register.
module alu32
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic   clk,
    input  logic   rst_n,
    alu32_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] c_reg;
    logic [WIDTH-1:0] c_next;
    logic [WIDTH-1:0] shift_result;
    logic [WIDTH-1:0] sum_result;
    logic [WIDTH-1:0] diff_result;
    shift_mode_e      shift_mode;

    assign shift_mode  = shift_mode_of(bus.ALUOp);
    assign sum_result  = bus.A + bus.B;
    assign diff_result = bus.A - bus.B;

    // Only the low SHW bits of B steer the shifter; upper bits are ignored.
    alu_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_shifter (
        .data   (bus.A),
        .amount (bus.B[SHW-1:0]),
        .mode   (shift_mode),
        .result (shift_result)
    );

    // Opcode mux: every opcode value yields a defined result.
    always_comb begin
        c_next = '0;
        case (bus.ALUOp)
            ALU_ADD: c_next = sum_result;
            ALU_SUB: c_next = diff_result;
            ALU_AND: c_next = bus.A & bus.B;
            ALU_OR:  c_next = bus.A | bus.B;
            ALU_SRL: c_next = shift_result;
            ALU_SRA: c_next = shift_result;
`ifdef ALU_EXT_OPS_EN
            ALU_SLT: c_next = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
            ALU_SLL: c_next = shift_result;
`else
            ALU_SLT: c_next = '0;
            ALU_SLL: c_next = '0;
`endif
            default: c_next = '0;
        endcase
    end

    // Result register: cleared at once by reset, otherwise loads every edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_reg <= '0;
        end else begin
            c_reg <= c_next;
        end
    end

    assign bus.C = c_reg;

endmodule : alu32

// File: tb/tb_alu32.sv
// Testbench for alu32: directed vectors with literal expectations, plus a
// behavioural reference model compared against C on every falling edge.
module tb_alu32;

`ifdef ALU_EXT_OPS_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] exp_c;

    alu32_if #(.WIDTH(32)) bus ();

    alu32 #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: what C must hold given one operation.
    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a >> sh;
            3'd5: return $unsigned($signed(a) >>> sh);
            3'd6: return (EXT && ($signed(a) < $signed(b))) ? 32'd1 : 32'd0;
            default: return EXT ? (a << sh) : 32'd0;
        endcase
    endfunction

    // Expected register contents: cleared by reset, else the model's result.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_c <= 32'd0;
        else        exp_c <= model(bus.ALUOp, bus.A, bus.B);
    end

    // Continuous comparison away from the active edge.
    always @(negedge clk) begin
        checks++;
        if (bus.C !== exp_c) begin
            errors++;
            $display("FAIL model_cmp t=%0t C=%08h expected=%08h", $time, bus.C, exp_c);
        end
    end

    task automatic check(input string name, input logic [31:0] want);
        checks++;
        if (bus.C !== want) begin
            errors++;
            $display("FAIL %s C=%08h expected=%08h", name, bus.C, want);
        end else begin
            $display("ok   %s C=%08h", name, bus.C);
        end
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #2;
        bus.ALUOp = op;
        bus.A     = a;
        bus.B     = b;
    endtask

    // One operation with a literal expectation; then scribble the inputs and
    // confirm C holds until the next edge.
    task automatic op_chk(input string name, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want);
        drive(op, a, b);
        @(posedge clk);
        #1;
        check(name, want);
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.ALUOp = 3'($urandom_range(0, 7));
        #1;
        check({name, "_hold"}, want);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        bus.A     = 32'h1234_5678;
        bus.B     = 32'h0000_0003;
        bus.ALUOp = 3'd0;
        #1 rst_n = 1'b0;
        #1 check("reset_async", 32'd0);
        // Inputs toggling while reset is held must not change C.
        repeat (3) begin
            drive(3'($urandom_range(0, 7)), $urandom, $urandom);
            @(posedge clk);
            #1 check("reset_hold", 32'd0);
        end

        // First edge after release loads the operation present at it.
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.A = 32'd5; bus.B = 32'd7; bus.ALUOp = 3'd0;
        @(posedge clk);
        #1 check("first_add", 32'd12);

        op_chk("add_wrap",  3'd0, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000);
        op_chk("sub_wrap",  3'd1, 32'd0,         32'd1, 32'hFFFF_FFFF);
        op_chk("and",       3'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0);
        op_chk("or",        3'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0);
        op_chk("sra1",      3'd5, 32'h8000_0000, 32'd1, 32'hC000_0000);
        op_chk("srl1",      3'd4, 32'h8000_0000, 32'd1, 32'h4000_0000);
        op_chk("sra_hiB",   3'd5, 32'h8000_0000, 32'h21, 32'hC000_0000);
        op_chk("srl_hiB",   3'd4, 32'h8000_0000, 32'h21, 32'h4000_0000);
        op_chk("srl0",      3'd4, 32'hDEAD_BEEF, 32'h20, 32'hDEAD_BEEF);
        op_chk("sra0",      3'd5, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF);
        op_chk("srl31",     3'd4, 32'h7FFF_FFFF, 32'd31, 32'h0000_0000);
        op_chk("sra31",     3'd5, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF);
        op_chk("sra4",      3'd5, 32'h9000_00F0, 32'd4, 32'hF900_000F);
        op_chk("slt",       3'd6, 32'hFFFF_FFFF, 32'd1, EXT ? 32'd1 : 32'd0);
        op_chk("slt_false", 3'd6, 32'd1, 32'hFFFF_FFFF, 32'd0);
        op_chk("sll31",     3'd7, 32'd1, 32'd31, EXT ? 32'h8000_0000 : 32'd0);
        op_chk("sll4",      3'd7, 32'h0F00_00F1, 32'd4, EXT ? 32'hF000_0F10 : 32'd0);

        // Back-to-back opcodes with fixed operands: each result one cycle later.
        op_chk("pipe_add", 3'd0, 32'h8000_0010, 32'd4, 32'h8000_0014);
        op_chk("pipe_sub", 3'd1, 32'h8000_0010, 32'd4, 32'h8000_000C);
        op_chk("pipe_sra", 3'd5, 32'h8000_0010, 32'd4, 32'hF800_0001);

        // Reset asserted mid-stream discards the in-flight result at once.
        drive(3'd0, 32'd100, 32'd23);
        @(posedge clk);
        #1 check("pre_reset", 32'd123);
        #2 rst_n = 1'b0;
        #1 check("midstream_reset", 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.A = 32'd40; bus.B = 32'd2; bus.ALUOp = 3'd0;
        @(posedge clk);
        #1 check("after_reset", 32'd42);

        // A few random operations left to the model comparison.
        repeat (20) drive(3'($urandom_range(0, 7)), $urandom, $urandom);
        @(negedge clk);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule : tb_alu32
